// File: rtl/param_memory.sv
// param_memory: single-port word memory behind a fixed-latency request FSM.
//
// A request is accepted in IDLE when valid=1. The address, direction, data
// and (optionally) byte strobes are captured. The access is performed
// LATENCY edges later, and ready pulses for one cycle at that point.
// Addresses at or beyond DEPTH do no access and raise err together with ready.
//
// Build option:
//   MEM_WSTRB_EN - adds the wstrb port. Only strobed byte lanes are written.
//                  WIDTH must then be a multiple of 8.
//
// Ports:
//   clk    - clock; all state changes on its rising edge
//   rst    - asynchronous active-high reset; clears the FSM, outputs and every word
//   valid  - request present (sampled only in IDLE)
//   wr_rd  - 1 = write, 0 = read
//   addr   - word address
//   wdata  - write data
//   wstrb  - byte-lane write enables (MEM_WSTRB_EN only)
//   rdata  - registered read data; holds until the next in-range read completes
//   ready  - one-cycle completion pulse
//   err    - out-of-range flag; only ever high together with ready
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for valid; captures the request on acceptance
// S_WAIT | counting down LATENCY-1 .. 0; the access happens when leaving at zero
// S_DONE | ready (and err) visible for this one cycle; always returns to IDLE

module param_memory #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
`ifdef MEM_WSTRB_EN
    input  logic [WIDTH/8-1:0]    wstrb,
`endif
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);
    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
`ifdef MEM_WSTRB_EN
    localparam int NB = WIDTH / 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef MEM_WSTRB_EN
    logic [NB-1:0]         wstrb_q, wstrb_d;
`endif
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];

    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [WIDTH-1:0]      merged;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
`ifdef MEM_WSTRB_EN
        wstrb_d = wstrb_q;
`endif
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_d   = mem_q;

        in_range = ({1'b0, addr_q} < DEPTH_L);
        // Truncation is safe: idx is only used when the address is in range.
        idx      = addr_q[IDX_W-1:0];

`ifdef MEM_WSTRB_EN
        merged = mem_q[idx];
        for (int k = 0; k < NB; k++) begin
            if (wstrb_q[k]) begin
                merged[k*8 +: 8] = wdata_q[k*8 +: 8];
            end
        end
`else
        merged = wdata_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                    addr_d  = addr;
                    wr_d    = wr_rd;
                    wdata_d = wdata;
`ifdef MEM_WSTRB_EN
                    wstrb_d = wstrb;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    err_d   = !in_range;
                    if (in_range) begin
                        if (wr_q) begin
                            mem_d[idx] = merged;
                        end else begin
                            rdata_d = mem_q[idx];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
`ifdef MEM_WSTRB_EN
            wstrb_q <= '0;
`endif
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
`ifdef MEM_WSTRB_EN
            wstrb_q <= wstrb_d;
`endif
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory. There are four instances that share one request bus:
//   u0: defaults (WIDTH 8, DEPTH 16, LATENCY 2)
//   u1: WIDTH 16, DEPTH 12, LATENCY 2
//   u2: WIDTH 16, DEPTH 12, LATENCY 1
//   u3: WIDTH 16, DEPTH 12, LATENCY 5
// A per-instance array memory model predicts ready/err/rdata on every cycle.

module tb_param_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [15:0] wdata;
`ifdef MEM_WSTRB_EN
    logic [1:0]  wstrb;
    localparam bit STRB = 1'b1;
`else
    localparam bit STRB = 1'b0;
`endif

    logic [7:0]  rdata0;
    logic [15:0] rdata1, rdata2, rdata3;
    logic        ready0, ready1, ready2, ready3;
    logic        err0, err1, err2, err3;

    param_memory u0 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata[7:0]),
`ifdef MEM_WSTRB_EN
        .wstrb(wstrb[0:0]),
`endif
        .rdata(rdata0), .ready(ready0), .err(err0)
    );

    param_memory #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4), .LATENCY(2)) u1 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata),
`ifdef MEM_WSTRB_EN
        .wstrb(wstrb),
`endif
        .rdata(rdata1), .ready(ready1), .err(err1)
    );

    param_memory #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4), .LATENCY(1)) u2 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata),
`ifdef MEM_WSTRB_EN
        .wstrb(wstrb),
`endif
        .rdata(rdata2), .ready(ready2), .err(err2)
    );

    param_memory #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4), .LATENCY(5)) u3 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata),
`ifdef MEM_WSTRB_EN
        .wstrb(wstrb),
`endif
        .rdata(rdata3), .ready(ready3), .err(err3)
    );

    int lat    [4] = '{2, 2, 1, 5};
    int dep    [4] = '{16, 12, 12, 12};
    int nbytes [4] = '{1, 2, 2, 2};

    logic [15:0] mm  [4][16];
    logic [15:0] mrd [4];

    int tests  = 0;
    int failed = 0;

    function automatic logic [15:0] get_rd(input int i);
        case (i)
            0:       return {8'h00, rdata0};
            1:       return rdata1;
            2:       return rdata2;
            default: return rdata3;
        endcase
    endfunction

    function automatic logic get_ready(input int i);
        case (i)
            0:       return ready0;
            1:       return ready1;
            2:       return ready2;
            default: return ready3;
        endcase
    endfunction

    function automatic logic get_err(input int i);
        case (i)
            0:       return err0;
            1:       return err1;
            2:       return err2;
            default: return err3;
        endcase
    endfunction

    task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s inst%0d: observed %h expected %h", tag, i, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mrd[i] = 16'h0000;
            for (int a = 0; a < 16; a++) mm[i][a] = 16'h0000;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_ready"}, i, 16'(get_ready(i)), 16'h0000);
            chk({tag, "_err"},   i, 16'(get_err(i)),   16'h0000);
            chk({tag, "_rdata"}, i, get_rd(i),         16'h0000);
        end
    endtask

    // This task is called on a falling edge. The request is accepted at the next
    // rising edge (edge 0). Every instance is then checked after edges 0..7.
    task automatic do_req(input bit wr, input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
        logic [15:0] nrd [4];
        bit          oor [4];
        logic [15:0] word;
        for (int i = 0; i < 4; i++) begin
            oor[i] = (int'(a) >= dep[i]);
            nrd[i] = mrd[i];
            if (!oor[i]) begin
                if (wr) begin
                    word = mm[i][a];
                    for (int b = 0; b < nbytes[i]; b++) begin
                        if (!STRB || s[b]) word[b*8 +: 8] = d[b*8 +: 8];
                    end
                    mm[i][a] = word;
                end else begin
                    nrd[i] = mm[i][a];
                end
            end
        end
        valid = 1'b1;
        wr_rd = wr;
        addr  = a;
        wdata = d;
`ifdef MEM_WSTRB_EN
        wstrb = s;
`endif
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                // Scramble the request bus. The captured copy must be the only one that matters.
                valid = 1'b0;
                wr_rd = 1'($urandom_range(0, 1));
                addr  = 4'($urandom);
                wdata = 16'($urandom);
`ifdef MEM_WSTRB_EN
                wstrb = 2'($urandom);
`endif
            end
            for (int i = 0; i < 4; i++) begin
                chk("ready", i, 16'(get_ready(i)), 16'(k == lat[i]));
                chk("err",   i, 16'(get_err(i)),   16'((k == lat[i]) && oor[i]));
                chk("rdata", i, get_rd(i), (k >= lat[i]) ? nrd[i] : mrd[i]);
            end
        end
        for (int i = 0; i < 4; i++) mrd[i] = nrd[i];
    endtask

    // valid stays high for 10 edges with a read of address 0. Acceptance follows the
    // throughput rule: after each acceptance at t, the next one can happen at t+L+2.
    task automatic held_valid();
        bit pulse [4][24];
        int next_ok;
        int cnt_obs, first_e, second_e;
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 24; t++) pulse[i][t] = 1'b0;
            next_ok = 0;
            for (int t = 0; t < 10; t++) begin
                if (t >= next_ok) begin
                    pulse[i][t + lat[i]] = 1'b1;
                    next_ok = t + lat[i] + 2;
                end
            end
        end
        cnt_obs  = 0;
        first_e  = -1;
        second_e = -1;
        valid = 1'b1;
        wr_rd = 1'b0;
        addr  = 4'd0;
        wdata = 16'h0000;
        for (int t = 0; t < 17; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (t == 9) valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                chk("held_ready", i, 16'(get_ready(i)), 16'(pulse[i][t]));
                chk("held_err",   i, 16'(get_err(i)),   16'h0000);
            end
            if (ready0 === 1'b1 && t < 10) begin
                cnt_obs++;
                if (first_e < 0) first_e = t;
                else if (second_e < 0) second_e = t;
            end
        end
        chk("held_pulses", 0, 16'(cnt_obs), 16'd2);
        chk("held_gap", 0, 16'(second_e - first_e), 16'(lat[0] + 2));
        for (int i = 0; i < 4; i++) begin
            mrd[i] = mm[i][0];
            chk("held_rdata", i, get_rd(i), mrd[i]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        wr_rd = 1'b0;
        addr  = 4'd0;
        wdata = 16'h0000;
`ifdef MEM_WSTRB_EN
        wstrb = 2'b00;
`endif
        model_clear();
        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_req(1'b1, 4'd7, 16'h005A, 2'b11);
        do_req(1'b0, 4'd7, 16'h0000, 2'b00);

        do_req(1'b0, 4'd13, 16'h0000, 2'b00);
        do_req(1'b1, 4'd12, 16'hBEEF, 2'b11);
        do_req(1'b0, 4'd12, 16'h0000, 2'b00);

        do_req(1'b1, 4'd2, 16'hFFFF, 2'b11);
        do_req(1'b1, 4'd2, 16'h1234, 2'b01);
        do_req(1'b0, 4'd2, 16'h0000, 2'b00);

        held_valid();

        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   16'($urandom), 2'($urandom_range(0, 3)));
        end
        for (int a = 0; a < 16; a++) begin
            do_req(1'b0, 4'(a), 16'h0000, 2'b00);
        end

        // A reset that arrives mid-WAIT must abort the write and wipe the array.
        do_req(1'b1, 4'd3, 16'h00A5, 2'b11);
        valid = 1'b1;
        wr_rd = 1'b1;
        addr  = 4'd3;
        wdata = 16'h0011;
`ifdef MEM_WSTRB_EN
        wstrb = 2'b11;
`endif
        @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_reset_outputs("rst_hold");
        end
        rst = 1'b0;
        model_clear();
        do_req(1'b0, 4'd3, 16'h0000, 2'b00);
        do_req(1'b0, 4'd7, 16'h0000, 2'b00);
        do_req(1'b1, 4'd5, 16'h00C3, 2'b11);
        do_req(1'b0, 4'd5, 16'h0000, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
